// File: rtl/opb_register_bank_simulink2ppc.sv
// OPB slave exposing C_NUM_REGS user words, a status word and an optional timestamp word.
// Define OPB_REG_BANK_TIMESTAMP_EN to add the free-running cycle timestamp word.
module opb_register_bank_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h01010100,
    parameter logic [31:0] C_HIGHADDR   = 32'h010101FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 4
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic                      Sl_xferAck,
    input  logic [C_NUM_REGS*32-1:0]  user_data_in,
    input  logic                      user_valid
);

    typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

    state_t      state, state_nxt;
    logic [31:0] live [C_NUM_REGS];
    logic [31:0] hold [C_NUM_REGS];
    logic [15:0] count;
    logic        stale;
    logic [31:0] rd_data_p1;
    logic [31:0] rd_mux;
    logic [31:0] ts_word;
    logic [31:0] addr_off;
    logic [29:0] idx;
    logic        hit, take, snap, clr;
    logic        unused_ok;

    assign addr_off  = OPB_ABus - C_BASEADDR;
    assign idx       = addr_off[31:2];
    assign hit       = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    // All side effects happen on the edge that accepts the transfer, so a snapshot
    // and the word 0 value it returns always come from the same pre-update state.
    assign take      = (state == IDLE) && hit;
    assign snap      = take && OPB_RNW && (idx == '0);
    assign clr       = take && !OPB_RNW && (idx == 30'(C_NUM_REGS)) && OPB_DBus[C_OPB_DWIDTH-1];
    assign unused_ok = ^{OPB_BE, OPB_seqAddr, OPB_DBus[0:C_OPB_DWIDTH-2], addr_off[1:0]};

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign Sl_xferAck = (state == ACK);
    assign Sl_DBus    = (state == ACK) ? rd_data_p1 : '0;

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hit) state_nxt = ACK;
            ACK:     state_nxt = WAIT;
            WAIT:    if (!OPB_select) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (idx == 30'(i)) rd_mux = hold[i];
        end
        if (idx == '0)                          rd_mux = live[0];
        else if (idx == 30'(C_NUM_REGS))        rd_mux = {count, 15'b0, stale};
        else if (idx == 30'(C_NUM_REGS + 1))    rd_mux = ts_word;
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                live[i] <= '0;
                hold[i] <= '0;
            end
            count      <= '0;
            stale      <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            if (take) rd_data_p1 <= OPB_RNW ? rd_mux : '0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (snap)       hold[i] <= live[i];
                if (user_valid) live[i] <= user_data_in[32*i +: 32];
            end
            // A PPC clear beats a coincident strobe increment.
            if (clr)             count <= '0;
            else if (user_valid) count <= count + 16'd1;
            if (user_valid)      stale <= 1'b1;
            else if (snap)       stale <= 1'b0;
        end
    end

`ifdef OPB_REG_BANK_TIMESTAMP_EN
    logic [31:0] ts_cnt, ts_live, ts_hold;

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            ts_cnt  <= '0;
            ts_live <= '0;
            ts_hold <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (user_valid) ts_live <= ts_cnt;
            if (snap)       ts_hold <= ts_live;
        end
    end

    assign ts_word = ts_hold;
`else
    assign ts_word = '0;
`endif

endmodule
